alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the combinational 16-bit ALU.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_seq_if.sv | 20 ++
 rtl/alu_iter_unit.sv | 107 ++++++++++
 rtl/alu_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode hi/lo nibble constants ({hi[7:4], lo[3:0]})
//   - flag bit positions inside the 5-bit {Z,C,F,N,L} flags word
//   - top-level FSM states and iterative-unit operation kinds
//   - mkflg(): packs individual flag bits into the flags word
package alu_pkg;

    // opcode high nibble (operation class)
    localparam logic [3:0] OPH_BASE  = 4'h0;
    localparam logic [3:0] OPH_ADDI  = 4'h5;
    localparam logic [3:0] OPH_ADDUI = 4'h6;
    localparam logic [3:0] OPH_ADDCI = 4'h7;
    localparam logic [3:0] OPH_SHIFT = 4'h8;

    // opcode low nibble, OPH_BASE class
    localparam logic [3:0] OPL_AND   = 4'h1;
    localparam logic [3:0] OPL_OR    = 4'h2;
    localparam logic [3:0] OPL_XOR   = 4'h3;
    localparam logic [3:0] OPL_NOT   = 4'h4;
    localparam logic [3:0] OPL_ADD   = 4'h5;
    localparam logic [3:0] OPL_ADDU  = 4'h6;
    localparam logic [3:0] OPL_ADDC  = 4'h7;
    localparam logic [3:0] OPL_ADDCU = 4'h8;
    localparam logic [3:0] OPL_SUB   = 4'h9;
    localparam logic [3:0] OPL_CMP   = 4'hB;
    localparam logic [3:0] OPL_CMPU  = 4'hF;

    // opcode low nibble, OPH_SHIFT class
    localparam logic [3:0] OPL_LSH   = 4'h0;
    localparam logic [3:0] OPL_RSH   = 4'h1;
    localparam logic [3:0] OPL_ARSH  = 4'h2;
    localparam logic [3:0] OPL_LSH1  = 4'h4;
    localparam logic [3:0] OPL_RSH1  = 4'h5;
    localparam logic [3:0] OPL_ARSH1 = 4'h6;

    // full opcode of the optional multiplier
    localparam logic [7:0] OP_MUL    = 8'hE0;

    // flag bit positions
    localparam int FLG_Z = 4;
    localparam int FLG_C = 3;
    localparam int FLG_F = 2;
    localparam int FLG_N = 1;
    localparam int FLG_L = 0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    typedef enum logic [1:0] {IT_LSH, IT_RSH, IT_ARSH, IT_MUL} iter_kind_e;

    function automatic logic [4:0] mkflg(input logic z, input logic c, input logic f,
                                         input logic n, input logic l);
        return {z, c, f, n, l};
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle of the sequential ALU.
//   in_valid/in_ready + a, b, opcode : operation request (master -> slave)
//   out_valid/out_ready + result, flags : result response (slave -> master)
//   slave modport is used by the ALU, master modport by its driver.
interface alu_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;

    modport slave  (input  in_valid, a, b, opcode, out_ready,
                    output in_ready, out_valid, result, flags);
    modport master (output in_valid, a, b, opcode, out_ready,
                    input  in_ready, out_valid, result, flags);
endinterface

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative engine, one step per clock.
//   Shifts (LSH/RSH/ARSH) move one bit per cycle; with ALU_MUL_EN defined
//   it also runs an unsigned shift-add multiply, one multiplier bit per cycle.
// Ports:
//   clk, reset   clock, async active-high reset (clears count and data)
//   start        load a/n/kind (and mcand) and begin; only while !busy
//   kind         operation kind (iter_kind_e)
//   a            shift operand / multiplier
//   mcand        multiplicand (ALU_MUL_EN only)
//   n            number of steps, must be >0 when start is asserted
//   busy         steps remaining
//   done         the step taken at the coming edge is the last one
//   res, cout    value and carry-out produced by the current step; the
//                caller captures them when done is high
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  iter_kind_e       kind,
    input  logic [WIDTH-1:0] a,
`ifdef ALU_MUL_EN
    input  logic [WIDTH-1:0] mcand,
`endif
    input  logic [SHW-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout
);

    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    iter_kind_e       kind_q;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] hi_q, hi_d, mcand_q;
    logic [WIDTH:0]   sum;
`endif

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == SHW'(1));

    // One step. For MUL, {hi_q, acc_q} is the partial product with the
    // not-yet-consumed multiplier bits in the low half of acc_q.
    always_comb begin
        res  = acc_q;
        cout = 1'b0;
`ifdef ALU_MUL_EN
        hi_d = hi_q;
        sum  = '0;
`endif
        case (kind_q)
            IT_LSH: begin
                res  = {acc_q[WIDTH-2:0], 1'b0};
                cout = acc_q[WIDTH-1];
            end
            IT_RSH: begin
                res  = {1'b0, acc_q[WIDTH-1:1]};
                cout = acc_q[0];
            end
            IT_ARSH: begin
                res  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                cout = acc_q[0];
            end
`ifdef ALU_MUL_EN
            IT_MUL: begin
                sum  = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
                hi_d = sum[WIDTH:1];
                res  = {sum[0], acc_q[WIDTH-1:1]};
                cout = (hi_d != '0);   // high half non-zero after the last step
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            kind_q  <= IT_LSH;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (start) begin
            acc_q   <= a;
            cnt_q   <= n;
            kind_q  <= kind;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= mcand;
`endif
        end else if (busy) begin
            acc_q   <= res;
            cnt_q   <= cnt_q - SHW'(1);
`ifdef ALU_MUL_EN
            hi_q    <= hi_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with an internal {Z,C,F,N,L} flags
// register. Single-cycle logic/arithmetic/compare ops, iterative shifts
// (one bit per cycle) and, when ALU_MUL_EN is defined, an iterative
// unsigned multiply at opcode 8'hE0 (otherwise 8'hE0 is a NOP).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high; aborts any operation in flight
//   bus    alu_seq_if.slave: in_valid/in_ready/a/b/opcode request side,
//          out_valid/out_ready/result/flags response side
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;

    logic [WIDTH-1:0] a, b;
    logic [3:0]       hi, lo;
    logic             out_valid, in_ready, accept;

    assign a  = bus.a;
    assign b  = bus.b;
    assign hi = bus.opcode[7:4];
    assign lo = bus.opcode[3:0];

    // DONE behaves as idle in the cycle its result is taken, so a new op
    // can be accepted without a bubble.
    logic it_busy;
    assign out_valid = (state_q == S_DONE);
    assign in_ready  = ~it_busy & (state_q != S_SHIFT) & (~out_valid | bus.out_ready);
    assign accept    = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // ---------------- single-cycle datapath / decode ----------------
    logic             cin;
    logic [WIDTH:0]   sum_ab, sum_abc, dif_ab;
    logic [SHW-1:0]   cnt_b, shn;

    assign cin     = flags_q[FLG_C];   // carry as held at accept time
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign sum_abc = sum_ab + {{WIDTH{1'b0}}, cin};
    assign dif_ab  = {1'b0, a} - {1'b0, b};
    assign cnt_b   = b[SHW-1:0];
    assign shn     = (cnt_b > SHW'(WIDTH)) ? SHW'(WIDTH) : cnt_b;

    function automatic logic add_ovf(input logic xa, input logic xb, input logic xr);
        return (xa == xb) & (xr != xa);
    endfunction

    logic [WIDTH-1:0] d_res;
    logic [4:0]       d_flg;
    logic             use_z, sh_op, d_iter;
    iter_kind_e       d_kind;
    logic [SHW-1:0]   d_cnt;

    always_comb begin
        d_res  = '0;
        d_flg  = '0;
        use_z  = 1'b1;     // Z = (result == 0) unless the op says otherwise
        sh_op  = 1'b0;
        d_iter = 1'b0;
        d_kind = IT_LSH;
        d_cnt  = '0;
        case (hi)
            OPH_BASE: begin
                case (lo)
                    OPL_AND:  d_res = a & b;
                    OPL_OR:   d_res = a | b;
                    OPL_XOR:  d_res = a ^ b;
                    OPL_NOT:  d_res = ~a;
                    OPL_ADD: begin
                        d_res        = sum_ab[MSB:0];
                        d_flg[FLG_C] = sum_ab[WIDTH];
                        d_flg[FLG_F] = add_ovf(a[MSB], b[MSB], sum_ab[MSB]);
                    end
                    OPL_ADDU: begin
                        d_res        = sum_ab[MSB:0];
                        d_flg[FLG_C] = sum_ab[WIDTH];
                    end
                    OPL_ADDC: begin
                        d_res        = sum_abc[MSB:0];
                        d_flg[FLG_C] = sum_abc[WIDTH];
                        d_flg[FLG_F] = add_ovf(a[MSB], b[MSB], sum_abc[MSB]);
                    end
                    OPL_ADDCU: begin
                        d_res        = sum_abc[MSB:0];
                        d_flg[FLG_C] = sum_abc[WIDTH];
                    end
                    OPL_SUB: begin
                        d_res        = dif_ab[MSB:0];
                        d_flg[FLG_C] = dif_ab[WIDTH];   // borrow
                        d_flg[FLG_F] = (a[MSB] != b[MSB]) & (dif_ab[MSB] != a[MSB]);
                    end
                    OPL_CMP: begin
                        use_z        = 1'b0;
                        d_flg[FLG_Z] = (a == b);
                        d_flg[FLG_N] = ($signed(a) < $signed(b));
                        d_flg[FLG_L] = ($signed(a) < $signed(b));
                    end
                    OPL_CMPU: begin
                        use_z        = 1'b0;
                        d_flg[FLG_Z] = (a == b);
                        d_flg[FLG_L] = (a < b);
                    end
                    default: use_z = 1'b0;
                endcase
            end
            OPH_ADDI: begin
                d_res        = sum_ab[MSB:0];
                d_flg[FLG_C] = sum_ab[WIDTH];
                d_flg[FLG_F] = add_ovf(a[MSB], b[MSB], sum_ab[MSB]);
            end
            OPH_ADDUI: begin
                d_res        = sum_ab[MSB:0];
                d_flg[FLG_C] = sum_ab[WIDTH];
            end
            OPH_ADDCI: begin
                d_res        = sum_abc[MSB:0];
                d_flg[FLG_C] = sum_abc[WIDTH];
                d_flg[FLG_F] = add_ovf(a[MSB], b[MSB], sum_abc[MSB]);
            end
            OPH_SHIFT: begin
                sh_op = 1'b1;
                case (lo)
                    OPL_LSH:   begin d_kind = IT_LSH;  d_cnt = shn;       end
                    OPL_RSH:   begin d_kind = IT_RSH;  d_cnt = shn;       end
                    OPL_ARSH:  begin d_kind = IT_ARSH; d_cnt = shn;       end
                    OPL_LSH1:  begin d_kind = IT_LSH;  d_cnt = SHW'(1);   end
                    OPL_RSH1:  begin d_kind = IT_RSH;  d_cnt = SHW'(1);   end
                    OPL_ARSH1: begin d_kind = IT_ARSH; d_cnt = SHW'(1);   end
                    default: begin
                        sh_op = 1'b0;
                        use_z = 1'b0;
                    end
                endcase
            end
            default: begin
                use_z = 1'b0;
`ifdef ALU_MUL_EN
                if (bus.opcode == OP_MUL) begin
                    d_iter = 1'b1;
                    d_kind = IT_MUL;
                    d_cnt  = SHW'(WIDTH);
                end
`endif
            end
        endcase
        // zero-count shift finishes in one cycle with result=A, C=0
        if (sh_op) begin
            if (d_cnt == '0) d_res  = a;
            else             d_iter = 1'b1;
        end
        if (use_z) d_flg[FLG_Z] = (d_res == '0);
    end

    // ---------------- iterative unit ----------------
    logic             it_start, it_done, it_cout;
    logic [WIDTH-1:0] it_res;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (it_start),
        .kind  (d_kind),
        .a     (a),
`ifdef ALU_MUL_EN
        .mcand (b),
`endif
        .n     (d_cnt),
        .busy  (it_busy),
        .done  (it_done),
        .res   (it_res),
        .cout  (it_cout)
    );

    // ---------------- FSM ----------------
    logic ld_dec, ld_it;

    always_comb begin
        state_d  = state_q;
        it_start = 1'b0;
        ld_dec   = 1'b0;
        ld_it    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (out_valid && bus.out_ready) state_d = S_IDLE;
                if (accept) begin
                    if (d_iter) begin
                        state_d  = S_SHIFT;
                        it_start = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        ld_dec   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (it_done) begin
                    state_d = S_DONE;
                    ld_it   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // result and flags change only on DONE entry, so they hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_dec) begin
                result_q <= d_res;
                flags_q  <= d_flg;
            end else if (ld_it) begin
                result_q <= it_res;
                flags_q  <= mkflg(it_res == '0, it_cout, 1'b0, 1'b0, 1'b0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    alu_seq_if #(.WIDTH(16)) bus();

    alu_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [4:0]  f;
        int          lat;    // 0 = latency not checked
        int          acyc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: compare every transferred result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got result %0h with nothing expected", bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_res"}, bus.result, e.r);
                check({e.nm, "_flg"}, bus.flags, e.f);
                if (e.lat > 0) check({e.nm, "_lat"}, cyc - e.acyc + 1, e.lat);
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [4:0] ef, input int lat,
                         input string nm, output int tries);
        exp_t e;
        bit   ok;
        ok = 0;
        tries = 0;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        while (!ok && tries < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok     = 1;
                e.r    = er;
                e.f    = ef;
                e.lat  = lat;
                e.acyc = cyc + 1;
                e.nm   = nm;
                sb.push_back(e);
            end else begin
                tries++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: not accepted within 200 cycles", nm);
        end
    endtask

    task automatic go(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] er, input logic [4:0] ef, input int lat, input string nm);
        int t;
        issue(op, av, bv, er, ef, lat, nm, t);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: %0d results still pending", nm, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.result,    0);
        check("rst_flags",     bus.flags,     0);
        check("rst_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;

        // flags {Z,C,F,N,L}
        go(8'h06, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000,  1, "addu");
        go(8'h08, 16'h0000, 16'h0000, 16'h0001, 5'b00000,  1, "addcu");   // Cin=1 from addu
        go(8'h0B, 16'hFFFE, 16'h0002, 16'h0000, 5'b00011,  1, "cmp");
        go(8'h0F, 16'hFFFE, 16'h0002, 16'h0000, 5'b00000,  1, "cmpu");
        go(8'h82, 16'h8000, 16'h0003, 16'hF000, 5'b00000,  4, "arsh3");
        go(8'h81, 16'h0001, 16'h0010, 16'h0000, 5'b10000, 17, "rsh16");
        go(8'h01, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000,  1, "and");
        go(8'h03, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b10000,  1, "xor");
        go(8'h04, 16'h0000, 16'h1234, 16'hFFFF, 5'b00000,  1, "not");
        go(8'h09, 16'h0001, 16'h0002, 16'hFFFF, 5'b01000,  1, "sub_borrow");
        go(8'h09, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100,  1, "sub_ovf");
        go(8'h80, 16'h0001, 16'h0010, 16'h0000, 5'b11000, 17, "lsh16");
        go(8'h80, 16'h1234, 16'h0040, 16'h1234, 5'b00000,  1, "lsh0");     // b[4:0]=0
        go(8'h80, 16'h0001, 16'h0023, 16'h0008, 5'b00000,  4, "lsh3_hib"); // upper b ignored
        go(8'h82, 16'h8000, 16'h001F, 16'hFFFF, 5'b01000, 17, "arsh_sat");
        go(8'h85, 16'h0002, 16'h0000, 16'h0001, 5'b00000,  2, "rsh1");
        go(8'h86, 16'h8001, 16'h0000, 16'hC000, 5'b01000,  2, "arsh1");
        go(8'h50, 16'h0005, 16'hFFFF, 16'h0004, 5'b01000,  1, "addi");
        go(8'h07, 16'h0001, 16'h0001, 16'h0003, 5'b00000,  1, "addc");     // Cin=1 from addi
        go(8'h84, 16'h8001, 16'h0000, 16'h0002, 5'b01000,  2, "lsh1");
        go(8'h0A, 16'h0001, 16'h0001, 16'h0000, 5'b00000,  1, "undef");
`ifdef ALU_MUL_EN
        go(8'hE0, 16'h0100, 16'h0100, 16'h0000, 5'b11000, 17, "mul");
`else
        go(8'hE0, 16'h0100, 16'h0100, 16'h0000, 5'b00000,  1, "e0_nop");
`endif

        // reset mid-shift aborts the op; flags are nonzero beforehand
        go(8'h84, 16'h8001, 16'h0000, 16'h0002, 5'b01000,  2, "lsh1_pre");
        go(8'h80, 16'h0001, 16'h0008, 16'h0100, 5'b00000,  9, "lsh8_abort");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_flags",     bus.flags,     0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready",  bus.in_ready,  1);
        check("postrst_out_valid", bus.out_valid, 0);
        check("postrst_result",    bus.result,    0);
        repeat (12) @(negedge clk);
        check("postrst_no_result", bus.out_valid, 0);
        check("postrst_flags",     bus.flags,     0);
        @(posedge clk);
        #1;

        // back-pressure: 7FFF+0001 has no carry out of bit 15, so C=0, F=1
        drain("pre_hold");
        bus.out_ready = 1'b0;
        go(8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 0, "add_hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_result",    bus.result,    16'h8000);
            check("hold_flags",     bus.flags,     5'b00100);
            check("hold_in_ready",  bus.in_ready,  0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(8'h02, 16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 1, "or_drain", tries);
        check("no_bubble_tries", tries, 0);

        drain("final");
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
